// File: rtl/change_state_machine.sv
// rtl/change_state_machine.sv - change/refund dispenser paired with the main payment FSM
//
// Purpose:
//   Captures the amount owed when the main FSM reports an invalid (2) or a
//   valid (3) payment, then pays it out one coin per clock, largest coin
//   first. When nothing is left it raises noMoneyLeft and holds it until the
//   main FSM leaves states 2/3.
//
// Ports:
//   clock        in   1  system clock, rising edge
//   reset        in   1  synchronous, active-high
//   mainState    in   3  main FSM state (0 wait, 1 inserted, 2 invalid, 3 valid, 4 thanks)
//   inputMoney   in   W  amount inserted by the user
//   valueToPay   in   W  price of the item
//   noMoneyLeft  out  1  payout finished; held until mainState leaves 2/3
//   coinValid    out  1  one-cycle pulse: a coin is dispensed this cycle
//   coinOut      out  W  value of the dispensed coin; 0 when coinValid=0
//   moneyLeft    out  W  change still owed
//   coinsGiven   out  W  coins dispensed in the current payout
//   changeState  out  2  0 IDLE, 1 DISPENSE, 2 DONE

module change_state_machine #(
    parameter int W     = 5,
    parameter int COIN0 = 10,
    parameter int COIN1 = 5,
    parameter int COIN2 = 2,
    parameter int COIN3 = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [2:0]   mainState,
    input  logic [W-1:0] inputMoney,
    input  logic [W-1:0] valueToPay,
    output logic         noMoneyLeft,
    output logic         coinValid,
    output logic [W-1:0] coinOut,
    output logic [W-1:0] moneyLeft,
    output logic [W-1:0] coinsGiven,
    output logic [1:0]   changeState
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPENSE = 2'd1,
        ST_DONE     = 2'd2
    } state_t;

    localparam logic [2:0] MAIN_INVALID = 3'd2;
    localparam logic [2:0] MAIN_VALID   = 3'd3;

    localparam logic [W-1:0] C0 = W'(COIN0);
    localparam logic [W-1:0] C1 = W'(COIN1);
    localparam logic [W-1:0] C2 = W'(COIN2);
    localparam logic [W-1:0] C3 = W'(COIN3);

    state_t       r_state;
    logic         r_no_money_left;
    logic         r_coin_valid;
    logic [W-1:0] r_coin_out;
    logic [W-1:0] r_money_left;
    logic [W-1:0] r_coins_given;

    logic [W-1:0] w_coin;
    logic [W-1:0] w_change;
    logic         w_pay_request;

    // Largest coin not exceeding the remaining amount. COIN3 is 1, so any
    // non-zero amount always selects a coin; zero only reaches here unused.
    always_comb begin
        w_coin = '0;
        if (r_money_left >= C0) begin
            w_coin = C0;
        end else if (r_money_left >= C1) begin
            w_coin = C1;
        end else if (r_money_left >= C2) begin
            w_coin = C2;
        end else if (r_money_left >= C3) begin
            w_coin = C3;
        end
    end

    // Change for a valid payment saturates at zero instead of wrapping when
    // the user inserted less than the price.
    always_comb begin
        w_change = '0;
        if (inputMoney >= valueToPay) begin
            w_change = inputMoney - valueToPay;
        end
    end

    assign w_pay_request = (mainState == MAIN_INVALID) || (mainState == MAIN_VALID);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_no_money_left <= 1'b0;
            r_coin_valid    <= 1'b0;
            r_coin_out      <= '0;
            r_money_left    <= '0;
            r_coins_given   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_no_money_left <= 1'b0;
                    r_coin_valid    <= 1'b0;
                    r_coin_out      <= '0;
                    // Amount is captured once here; inputs are not looked at
                    // again until the next load.
                    if (mainState == MAIN_INVALID) begin
                        r_money_left  <= inputMoney;
                        r_coins_given <= '0;
                        r_state       <= ST_DISPENSE;
                    end else if (mainState == MAIN_VALID) begin
                        r_money_left  <= w_change;
                        r_coins_given <= '0;
                        r_state       <= ST_DISPENSE;
                    end
                end

                ST_DISPENSE: begin
                    // mainState is deliberately ignored until payout ends.
                    if (r_money_left == '0) begin
                        r_coin_valid    <= 1'b0;
                        r_coin_out      <= '0;
                        r_no_money_left <= 1'b1;
                        r_state         <= ST_DONE;
                    end else begin
                        r_coin_out    <= w_coin;
                        r_coin_valid  <= 1'b1;
                        r_money_left  <= r_money_left - w_coin;
                        r_coins_given <= r_coins_given + 1'b1;
                    end
                end

                ST_DONE: begin
                    r_coin_valid <= 1'b0;
                    r_coin_out   <= '0;
                    // Hold completion until the main FSM moves on, so the
                    // same request can never trigger a second payout.
                    if (!w_pay_request) begin
                        r_no_money_left <= 1'b0;
                        r_state         <= ST_IDLE;
                    end else begin
                        r_no_money_left <= 1'b1;
                    end
                end

                default: begin
                    r_state         <= ST_IDLE;
                    r_no_money_left <= 1'b0;
                    r_coin_valid    <= 1'b0;
                    r_coin_out      <= '0;
                end
            endcase
        end
    end

    assign noMoneyLeft = r_no_money_left;
    assign coinValid   = r_coin_valid;
    assign coinOut     = r_coin_out;
    assign moneyLeft   = r_money_left;
    assign coinsGiven  = r_coins_given;
    assign changeState = r_state;

endmodule

// File: tb/tb_change_state_machine.sv
// tb/tb_change_state_machine.sv - directed self-checking bench for change_state_machine

module tb_change_state_machine;

    localparam int W = 5;

    logic         clock;
    logic         reset;
    logic [2:0]   main_state;
    logic [W-1:0] input_money;
    logic [W-1:0] value_to_pay;
    logic         no_money_left;
    logic         coin_valid;
    logic [W-1:0] coin_out;
    logic [W-1:0] money_left;
    logic [W-1:0] coins_given;
    logic [1:0]   change_state;

    int n_checks = 0;
    int n_fail   = 0;

    change_state_machine #(
        .W(W), .COIN0(10), .COIN1(5), .COIN2(2), .COIN3(1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .mainState   (main_state),
        .inputMoney  (input_money),
        .valueToPay  (value_to_pay),
        .noMoneyLeft (no_money_left),
        .coinValid   (coin_valid),
        .coinOut     (coin_out),
        .moneyLeft   (money_left),
        .coinsGiven  (coins_given),
        .changeState (change_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One rising edge, then settle at the falling edge where inputs are
    // driven and outputs sampled.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, ".state"}, 32'(change_state), 0);
        check({tag, ".nml"},   32'(no_money_left), 0);
        check({tag, ".valid"}, 32'(coin_valid), 0);
        check({tag, ".coin"},  32'(coin_out), 0);
        check({tag, ".left"},  32'(money_left), 0);
        check({tag, ".given"}, 32'(coins_given), 0);
    endtask

    // Starts a payout and checks the load edge, every coin edge and the
    // DONE edge. Expected remaining amount is computed here from the request.
    task automatic payout(input string tag, input logic [2:0] ms, input int in_m, input int pay,
                          input int n, input int c0, input int c1, input int c2, input int c3);
        int coins[4];
        int left;
        coins[0] = c0; coins[1] = c1; coins[2] = c2; coins[3] = c3;
        if (ms == 3'd3) left = (in_m > pay) ? in_m - pay : 0;
        else            left = in_m;

        main_state   = ms;
        input_money  = W'(in_m);
        value_to_pay = W'(pay);
        step();
        check({tag, ".load.state"}, 32'(change_state), 1);
        check({tag, ".load.left"},  32'(money_left), 32'(left));
        check({tag, ".load.given"}, 32'(coins_given), 0);
        check({tag, ".load.valid"}, 32'(coin_valid), 0);
        check({tag, ".load.nml"},   32'(no_money_left), 0);

        // Changing inputs after entry must not affect the payout.
        input_money  = 5'd7;
        value_to_pay = 5'd0;

        for (int i = 0; i < n; i++) begin
            step();
            left = left - coins[i];
            check({tag, ".coin.valid"}, 32'(coin_valid), 1);
            check({tag, ".coin.value"}, 32'(coin_out), 32'(coins[i]));
            check({tag, ".coin.left"},  32'(money_left), 32'(left));
            check({tag, ".coin.given"}, 32'(coins_given), 32'(i + 1));
            check({tag, ".coin.nml"},   32'(no_money_left), 0);
        end

        step();
        check({tag, ".done.state"}, 32'(change_state), 2);
        check({tag, ".done.nml"},   32'(no_money_left), 1);
        check({tag, ".done.valid"}, 32'(coin_valid), 0);
        check({tag, ".done.coin"},  32'(coin_out), 0);
        check({tag, ".done.left"},  32'(money_left), 0);
        check({tag, ".done.given"}, 32'(coins_given), 32'(n));
    endtask

    task automatic release_done(input string tag, input int n);
        main_state = 3'd4;
        step();
        check({tag, ".rel.state"}, 32'(change_state), 0);
        check({tag, ".rel.nml"},   32'(no_money_left), 0);
        check({tag, ".rel.given"}, 32'(coins_given), 32'(n));
        main_state = 3'd0;
        step();
        check({tag, ".idle.state"}, 32'(change_state), 0);
        check({tag, ".idle.valid"}, 32'(coin_valid), 0);
    endtask

    initial begin
        reset        = 1'b1;
        main_state   = 3'd0;
        input_money  = '0;
        value_to_pay = '0;
        @(negedge clock);
        step();
        check_idle_zero("reset");
        reset = 1'b0;

        // Wait / inserted states must not start a payout.
        main_state  = 3'd1;
        input_money = 5'd9;
        step();
        step();
        check_idle_zero("no_start");
        main_state = 3'd0;

        // Valid 28/2: 26 -> 10,10,5,1, then DONE held while mainState stays 3.
        payout("valid28", 3'd3, 28, 2, 4, 10, 10, 5, 1);
        main_state = 3'd3;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold.state", 32'(change_state), 2);
            check("hold.nml",   32'(no_money_left), 1);
            check("hold.valid", 32'(coin_valid), 0);
        end
        release_done("valid28", 4);

        // Invalid 1/4: whole inserted amount is refunded.
        payout("invalid1", 3'd2, 1, 4, 1, 1, 0, 0, 0);
        release_done("invalid1", 1);

        // Exact payment: no coin, noMoneyLeft two edges after entry.
        payout("exact4", 3'd3, 4, 4, 0, 0, 0, 0, 0);
        release_done("exact4", 0);

        // Underpayment in valid state saturates to zero.
        payout("under", 3'd3, 3, 7, 0, 0, 0, 0, 0);
        release_done("under", 0);

        // Maximum amount refunded.
        payout("max31", 3'd2, 31, 0, 4, 10, 10, 10, 1);
        release_done("max31", 4);

        // Mixed coins: 9 = 5 + 2 + 2.
        payout("mix9", 3'd3, 20, 11, 3, 5, 2, 2, 0);
        release_done("mix9", 3);

        // Reset after two coins of a 28/2 payout.
        main_state   = 3'd3;
        input_money  = 5'd28;
        value_to_pay = 5'd2;
        step();
        step();
        step();
        check("mid.given", 32'(coins_given), 2);
        check("mid.left",  32'(money_left), 6);
        reset      = 1'b1;
        main_state = 3'd0;
        step();
        check_idle_zero("midreset");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("after_reset.valid", 32'(coin_valid), 0);
            check("after_reset.state", 32'(change_state), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
